// File: rtl/ysyx_22051013_bpu_dynamic_pkg.sv
// Shared decode constants and encodings for the dynamic ID-stage branch predictor.
package ysyx_22051013_bpu_dynamic_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  localparam logic [1:0] BHT_INIT_DEF = 2'b01;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_JAL = 2'd1,
    SRC_BHT = 2'd2,
    SRC_RAS = 2'd3
  } pred_src_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ysyx_22051013_bpu_dynamic_ras.sv
// Return-address stack: circular buffer with saturating occupancy count.
module ysyx_22051013_ras #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_addr_i,
  output logic [PC_W-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  stack_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;

  // ptr_q is the next free slot; the top entry sits one below it.
  assign top_idx = ptr_q - PTR_W'(1);
  assign empty_o = (cnt_q == '0);
  assign top_o   = stack_q[top_idx];

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (flush_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push_i && pop_i && !empty_o) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      // Full push wraps onto the oldest entry; count saturates.
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) stack_q[wr_idx] <= push_addr_i;
  end

endmodule

// File: rtl/ysyx_22051013_bpu_dynamic.sv
// ID-stage next-PC predictor: JAL always taken, BHT for branches, RAS for returns.
module ysyx_22051013_bpu_dynamic
  import ysyx_22051013_bpu_dynamic_pkg::*;
#(
  parameter int unsigned PC_W      = 64,
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned RAS_DEPTH = 4,
  parameter logic [1:0]  BHT_INIT  = BHT_INIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] pc_i,
  input  logic            id_fire,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            flush,
  output logic [PC_W-1:0] pc_o,
  output logic            bpu_jump,
  output logic [1:0]      pred_src
);

  localparam int unsigned BHT_N = 2 ** BHT_IDX_W;

  logic [1:0]           bht_q [BHT_N];
  logic [6:0]           opcode;
  logic [4:0]           rd, rs1;
  logic                 is_jal, is_jalr, is_branch, is_return;
  logic                 ras_push, ras_pop, ras_empty;
  logic [PC_W-1:0]      ras_top, seq_pc, jimm, bimm;
  logic [BHT_IDX_W-1:0] lk_idx, up_idx;
  logic [1:0]           lk_ctr, up_ctr;
  pred_src_e            src;
  logic                 unused_upd_pc;

  assign opcode    = inst[6:0];
  assign rd        = inst[11:7];
  assign rs1       = inst[19:15];
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_return = is_jalr && (rd == '0) && is_link(rs1);

  assign jimm   = PC_W'($signed(imm_j(inst)));
  assign bimm   = PC_W'($signed(imm_b(inst)));
  assign seq_pc = pc_i + PC_W'(4);

  assign lk_idx = pc_i[BHT_IDX_W+1:2];
  assign up_idx = upd_pc[BHT_IDX_W+1:2];
  assign lk_ctr = bht_q[lk_idx];
  assign up_ctr = bht_q[up_idx];

  assign unused_upd_pc = ^{upd_pc[PC_W-1:BHT_IDX_W+2], upd_pc[1:0]};

  // A coroutine swap (jalr with distinct link rd and rs1) pops and pushes at once.
  assign ras_push = id_fire && (is_jal || is_jalr) && is_link(rd);
  assign ras_pop  = id_fire && is_jalr && is_link(rs1) &&
                    ((rd == '0) || (is_link(rd) && (rd != rs1)));

  ysyx_22051013_ras #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_addr_i (seq_pc),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

  always_comb begin
    pc_o     = seq_pc;
    bpu_jump = 1'b0;
    src      = SRC_SEQ;
    if (rst) begin
      pc_o = '0;
    end else if (is_jal) begin
      pc_o     = pc_i + jimm;
      bpu_jump = 1'b1;
      src      = SRC_JAL;
    end else if (is_branch && lk_ctr[1]) begin
      pc_o     = pc_i + bimm;
      bpu_jump = 1'b1;
      src      = SRC_BHT;
    end else if (is_return && !ras_empty) begin
      pc_o     = ras_top;
      bpu_jump = 1'b1;
      src      = SRC_RAS;
    end
  end

  assign pred_src = src;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_N; i++) bht_q[i] <= BHT_INIT;
    end else if (upd_valid) begin
      if (upd_taken && (up_ctr != 2'b11))       bht_q[up_idx] <= up_ctr + 2'd1;
      else if (!upd_taken && (up_ctr != 2'b00)) bht_q[up_idx] <= up_ctr - 2'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_bpu_dynamic.sv
// Scenario bench for the dynamic branch predictor with an expected-result queue.
module tb_ysyx_22051013_bpu_dynamic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'h13;
  logic [63:0] pc_i = '0;
  logic        id_fire = 1'b0;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] pc_o;
  logic        bpu_jump;
  logic [1:0]  pred_src;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic r; logic [31:0] inst; logic [63:0] pc; logic fire;
    logic uv; logic [63:0] upc; logic ut; logic fl;
    logic [63:0] epc; logic ej; logic [1:0] es;
  } row_t;

  typedef struct { logic [63:0] pc; logic jump; logic [1:0] src; string name; } exp_t;

  exp_t sb[$];
  exp_t e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  ysyx_22051013_bpu_dynamic dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .pc_i      (pc_i),
    .id_fire   (id_fire),
    .upd_valid (upd_valid),
    .upd_pc    (upd_pc),
    .upd_taken (upd_taken),
    .flush     (flush),
    .pc_o      (pc_o),
    .bpu_jump  (bpu_jump),
    .pred_src  (pred_src)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic row_t mk(input logic r, input logic [31:0] in, input logic [63:0] pc,
                              input logic fire, input logic uv, input logic [63:0] upc,
                              input logic ut, input logic fl, input logic [63:0] epc,
                              input logic ej, input logic [1:0] es);
    row_t x;
    x.r = r; x.inst = in; x.pc = pc; x.fire = fire; x.uv = uv; x.upc = upc;
    x.ut = ut; x.fl = fl; x.epc = epc; x.ej = ej; x.es = es;
    return x;
  endfunction

  // Drives one cycle of inputs just after the edge and queues what the outputs must be.
  task automatic apply(input row_t x, input string nm);
    @(posedge clk);
    #1;
    rst = x.r; inst = x.inst; pc_i = x.pc; id_fire = x.fire;
    upd_valid = x.uv; upd_pc = x.upc; upd_taken = x.ut; flush = x.fl;
    sb.push_back('{pc: x.epc, jump: x.ej, src: x.es, name: nm});
    @(negedge clk);
  endtask

  task automatic test_reset();
    row_t rows[$];
    rows.push_back(mk(1, enc_jal(5'd1, 21'h100), 64'h8000_1000, 0, 0, 0, 0, 0, 64'h0, 0, 2'd0));
    rows.push_back(mk(1, enc_br(13'd16), 64'h8000_0000, 0, 0, 0, 0, 0, 64'h0, 0, 2'd0));
    foreach (rows[i]) begin
      apply(rows[i], $sformatf("reset[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || bpu_jump !== e.jump || pred_src !== e.src) begin
        failures++;
        $display("FAIL %s: got pc_o=%h jump=%b src=%0d, want pc_o=%h jump=%b src=%0d",
                 e.name, pc_o, bpu_jump, pred_src, e.pc, e.jump, e.src);
      end
    end
  endtask

  task automatic test_bht();
    row_t rows[$];
    logic [63:0] p0 = 64'h8000_0000;
    logic [31:0] br = enc_br(13'd16);
    rows.push_back(mk(0, br,  p0,      0, 0, 0,  0, 0, p0 + 4,      0, 2'd0));
    rows.push_back(mk(0, NOP, 64'h100, 0, 1, p0, 1, 0, 64'h104,     0, 2'd0));
    rows.push_back(mk(0, NOP, 64'h100, 0, 1, p0, 1, 0, 64'h104,     0, 2'd0));
    rows.push_back(mk(0, br,  p0,      0, 0, 0,  0, 0, 64'h8000_0010, 1, 2'd2));
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(0, NOP, 64'h100, 0, 1, p0, 0, 0, 64'h104, 0, 2'd0));
    rows.push_back(mk(0, br,  p0,      0, 0, 0,  0, 0, p0 + 4,      0, 2'd0));
    rows.push_back(mk(0, NOP, 64'h100, 0, 1, p0, 0, 0, 64'h104,     0, 2'd0));
    rows.push_back(mk(0, NOP, 64'h100, 0, 1, p0, 1, 0, 64'h104,     0, 2'd0));
    rows.push_back(mk(0, br,  p0,      0, 0, 0,  0, 0, p0 + 4,      0, 2'd0));
    rows.push_back(mk(0, NOP, 64'h100, 0, 1, p0, 1, 0, 64'h104,     0, 2'd0));
    rows.push_back(mk(0, br,  p0,      0, 0, 0,  0, 0, 64'h8000_0010, 1, 2'd2));
    foreach (rows[i]) begin
      apply(rows[i], $sformatf("bht[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || bpu_jump !== e.jump || pred_src !== e.src) begin
        failures++;
        $display("FAIL %s: got pc_o=%h jump=%b src=%0d, want pc_o=%h jump=%b src=%0d",
                 e.name, pc_o, bpu_jump, pred_src, e.pc, e.jump, e.src);
      end
    end
  endtask

  task automatic test_same_cycle();
    row_t rows[$];
    logic [63:0] p5 = 64'h8000_0040;
    rows.push_back(mk(0, enc_br(13'd16), p5, 0, 1, p5, 1, 0, p5 + 4,  0, 2'd0));
    rows.push_back(mk(0, enc_br(13'd16), p5, 0, 0, 0,  0, 0, p5 + 16, 1, 2'd2));
    foreach (rows[i]) begin
      apply(rows[i], $sformatf("same_cycle[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || bpu_jump !== e.jump || pred_src !== e.src) begin
        failures++;
        $display("FAIL %s: got pc_o=%h jump=%b src=%0d, want pc_o=%h jump=%b src=%0d",
                 e.name, pc_o, bpu_jump, pred_src, e.pc, e.jump, e.src);
      end
    end
  endtask

  task automatic test_call_ret();
    row_t rows[$];
    logic [31:0] ret = enc_jalr(5'd0, 5'd1);
    rows.push_back(mk(0, enc_jal(5'd1, 21'h100), 64'h8000_1000, 1, 0, 0, 0, 0, 64'h8000_1100, 1, 2'd1));
    rows.push_back(mk(0, ret, 64'h8000_1100, 1, 0, 0, 0, 0, 64'h8000_1004, 1, 2'd3));
    rows.push_back(mk(0, ret, 64'h8000_1104, 1, 0, 0, 0, 0, 64'h8000_1108, 0, 2'd0));
    foreach (rows[i]) begin
      apply(rows[i], $sformatf("call_ret[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || bpu_jump !== e.jump || pred_src !== e.src) begin
        failures++;
        $display("FAIL %s: got pc_o=%h jump=%b src=%0d, want pc_o=%h jump=%b src=%0d",
                 e.name, pc_o, bpu_jump, pred_src, e.pc, e.jump, e.src);
      end
    end
  endtask

  task automatic test_ras_overflow();
    row_t rows[$];
    logic [63:0] p, rp;
    for (int k = 0; k < 5; k++) begin
      p = 64'h8000_2000 + 64'(k) * 64'h100;
      rows.push_back(mk(0, enc_jal((k % 2 == 0) ? 5'd1 : 5'd5, 21'h100), p, 1, 0, 0, 0, 0,
                        p + 64'h100, 1, 2'd1));
    end
    for (int j = 0; j < 5; j++) begin
      rp = 64'h8000_3000 + 64'(j) * 4;
      if (j < 4)
        rows.push_back(mk(0, enc_jalr(5'd0, 5'd5), rp, 1, 0, 0, 0, 0,
                          64'h8000_2000 + 64'(4 - j) * 64'h100 + 4, 1, 2'd3));
      else
        rows.push_back(mk(0, enc_jalr(5'd0, 5'd5), rp, 1, 0, 0, 0, 0, rp + 4, 0, 2'd0));
    end
    foreach (rows[i]) begin
      apply(rows[i], $sformatf("ras_overflow[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || bpu_jump !== e.jump || pred_src !== e.src) begin
        failures++;
        $display("FAIL %s: got pc_o=%h jump=%b src=%0d, want pc_o=%h jump=%b src=%0d",
                 e.name, pc_o, bpu_jump, pred_src, e.pc, e.jump, e.src);
      end
    end
  endtask

  task automatic test_swap_and_nofire();
    row_t rows[$];
    logic [31:0] ret = enc_jalr(5'd0, 5'd1);
    rows.push_back(mk(0, enc_jal(5'd5, 21'h40), 64'h8000_4000, 1, 0, 0, 0, 0, 64'h8000_4040, 1, 2'd1));
    rows.push_back(mk(0, enc_jalr(5'd1, 5'd5), 64'h8000_5000, 1, 0, 0, 0, 0, 64'h8000_5004, 0, 2'd0));
    rows.push_back(mk(0, ret, 64'h8000_6000, 1, 0, 0, 0, 0, 64'h8000_5004, 1, 2'd3));
    rows.push_back(mk(0, ret, 64'h8000_6004, 1, 0, 0, 0, 0, 64'h8000_6008, 0, 2'd0));
    rows.push_back(mk(0, enc_jal(5'd1, 21'h100), 64'h8000_7000, 0, 0, 0, 0, 0, 64'h8000_7100, 1, 2'd1));
    rows.push_back(mk(0, ret, 64'h8000_7100, 1, 0, 0, 0, 0, 64'h8000_7104, 0, 2'd0));
    rows.push_back(mk(0, enc_jal(5'd1, 21'h100), 64'h8000_7200, 1, 0, 0, 0, 0, 64'h8000_7300, 1, 2'd1));
    rows.push_back(mk(0, ret, 64'h8000_7300, 0, 0, 0, 0, 0, 64'h8000_7204, 1, 2'd3));
    rows.push_back(mk(0, ret, 64'h8000_7300, 1, 0, 0, 0, 0, 64'h8000_7204, 1, 2'd3));
    rows.push_back(mk(0, ret, 64'h8000_7400, 1, 0, 0, 0, 0, 64'h8000_7404, 0, 2'd0));
    foreach (rows[i]) begin
      apply(rows[i], $sformatf("swap_nofire[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || bpu_jump !== e.jump || pred_src !== e.src) begin
        failures++;
        $display("FAIL %s: got pc_o=%h jump=%b src=%0d, want pc_o=%h jump=%b src=%0d",
                 e.name, pc_o, bpu_jump, pred_src, e.pc, e.jump, e.src);
      end
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    logic [63:0] p6 = 64'h8000_0080;
    rows.push_back(mk(0, enc_jal(5'd1, 21'h100), 64'h8000_8000, 1, 0, 0, 0, 0, 64'h8000_8100, 1, 2'd1));
    rows.push_back(mk(0, enc_jal(5'd1, 21'h100), 64'h8000_9000, 1, 1, p6, 1, 1, 64'h8000_9100, 1, 2'd1));
    rows.push_back(mk(0, enc_jalr(5'd0, 5'd1), 64'h8000_9100, 1, 0, 0, 0, 0, 64'h8000_9104, 0, 2'd0));
    rows.push_back(mk(0, enc_br(13'd16), p6, 0, 0, 0, 0, 0, p6 + 16, 1, 2'd2));
    foreach (rows[i]) begin
      apply(rows[i], $sformatf("flush[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || bpu_jump !== e.jump || pred_src !== e.src) begin
        failures++;
        $display("FAIL %s: got pc_o=%h jump=%b src=%0d, want pc_o=%h jump=%b src=%0d",
                 e.name, pc_o, bpu_jump, pred_src, e.pc, e.jump, e.src);
      end
    end
  endtask

  task automatic test_mid_reset();
    row_t rows[$];
    logic [63:0] p0 = 64'h8000_0000;
    logic [63:0] p5 = 64'h8000_0040;
    rows.push_back(mk(0, enc_jal(5'd1, 21'h100), 64'h8000_A000, 1, 0, 0, 0, 0, 64'h8000_A100, 1, 2'd1));
    rows.push_back(mk(1, enc_br(13'd16), p0, 1, 1, p0, 1, 0, 64'h0, 0, 2'd0));
    rows.push_back(mk(0, enc_br(13'd16), p0, 0, 0, 0, 0, 0, p0 + 4, 0, 2'd0));
    rows.push_back(mk(0, enc_br(13'd16), p5, 0, 0, 0, 0, 0, p5 + 4, 0, 2'd0));
    rows.push_back(mk(0, enc_jalr(5'd0, 5'd1), 64'h8000_A100, 1, 0, 0, 0, 0, 64'h8000_A104, 0, 2'd0));
    foreach (rows[i]) begin
      apply(rows[i], $sformatf("mid_reset[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (pc_o !== e.pc || bpu_jump !== e.jump || pred_src !== e.src) begin
        failures++;
        $display("FAIL %s: got pc_o=%h jump=%b src=%0d, want pc_o=%h jump=%b src=%0d",
                 e.name, pc_o, bpu_jump, pred_src, e.pc, e.jump, e.src);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bht();
    test_same_cycle();
    test_call_ret();
    test_ras_overflow();
    test_swap_and_nofire();
    test_flush();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_bpu_dynamic.md
Name: ysyx_22051013_bpu_dynamic

Overview:
Parametrised successor to the static ID-stage branch predictor. It predicts the next PC for the instruction in decode.
- Conditional branches use a PC-indexed table of 2-bit saturating counters (BHT), trained by the EX stage.
- Function returns use a return-address stack (RAS).
- JAL is always taken.
Outputs feed the IF-stage PC mux. Mispredict recovery stays in EX.

Parameters:
PC_W, 64, PC and data width
BHT_IDX_W, 6, log2 of BHT entries (64); index = pc[BHT_IDX_W+1:2]
RAS_DEPTH, 4, RAS entries (power of 2, >=2)
BHT_INIT, 2'b01, counter reset value (weakly not-taken)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
inst  in  32  instruction in ID
pc_i  in  PC_W  PC of inst
id_fire  in  1  inst accepted by ID this cycle; RAS commits only when high
upd_valid  in  1  EX resolved a conditional branch
upd_pc  in  PC_W  PC of resolved branch
upd_taken  in  1  actual direction
flush  in  1  pipeline redirect from EX; RAS state cleared
pc_o  out  PC_W  predicted next PC
bpu_jump  out  1  prediction is a redirect (not pc_i+4)
pred_src  out  2  0 seq, 1 jal, 2 bht, 3 ras

Behaviour:
- Lookup is combinational in the same cycle; state changes only on the clk rising edge.
- While rst=1: pc_o=0, bpu_jump=0, pred_src=0. On the next edge all BHT entries are set to BHT_INIT, and RAS count and top pointer are set to 0.
- Immediates: J, B and I formats, sign-extended to PC_W. All target arithmetic is modulo 2^PC_W.
- JAL (opcode 1101111): pc_o = pc_i + jimm; bpu_jump=1; src=1.
- Branch (opcode 1100011): counter c = BHT[pc_i idx].
  - c[1]=1: pc_o = pc_i + bimm, bpu_jump=1, src=2.
  - Otherwise: pc_i+4, bpu_jump=0, src=0.
- JALR is a return when rd is x0 and rs1 is x1 or x5.
  - Return with RAS non-empty: pc_o = top, bpu_jump=1, src=3.
  - Return with RAS empty, or any other JALR: pc_i+4, bpu_jump=0.
- All other opcodes: pc_i+4, bpu_jump=0, src=0.
- RAS push: on JAL/JALR with rd in {x1,x5} and id_fire=1, push pc_i+4.
- RAS pop: on a return with id_fire=1.
- Push and pop in the same cycle (JALR rd=x1, rs1=x5, rd≠rs1): top is replaced, count unchanged.
- RAS full push: pointer wraps and overwrites the oldest entry; count saturates at RAS_DEPTH.
- RAS empty pop: no-op.
- flush=1: count is set to 0 at the edge and overrides any push/pop in the same cycle.
- id_fire=0: no RAS change, but the prediction outputs stay valid.
- BHT update: when upd_valid=1, counter at upd_pc idx is incremented (taken) or decremented (not taken). It saturates at 3 and 0.
- Lookup and update of the same index in the same cycle: the lookup sees the pre-update value; the new value is visible next cycle.
- BHT update proceeds regardless of flush.
- rst has priority over every other input.

Decomposition:
- Shared define file gets:
  - opcode constants (JAL, JALR, BRANCH)
  - register numbers RA=1 and T0=5
  - pred_src encodings
  - BHT_INIT
- Natural single sub-module: ysyx_22051013_ras (push/pop/flush, top, empty).
- The BHT stays in the top module as a register array.

Test Plan:
1. Reset, then a branch at pc 0x80000000 with bimm=+16 → counter 01, bpu_jump=0, pc_o=0x80000004.
2. Two upd_valid taken updates at 0x80000000, then lookup → bpu_jump=1, pc_o=0x80000010. Three not-taken updates → counter 00; a further not-taken stays 00.
3. jal x1,+0x100 at 0x80001000 (id_fire) → pc_o=0x80001100, src=1. Then ret → pc_o=0x80001004, src=3, RAS empty after.
4. RAS_DEPTH+1 nested calls (pc+4 values A0..A4), then 5 returns → A4,A3,A2,A1 predicted; 5th return empty → pc_i+4, bpu_jump=0.
5. Update and lookup of the same index in one cycle at counter 01 with taken → that cycle not-taken, next cycle taken.
6. Call with flush=1 in the same cycle, then ret → RAS empty, bpu_jump=0. Also: rst asserted mid-stream → outputs 0, BHT back to 01.
